bnn_run_controller: RTL
=======================

BNN_RUN_CONTROLLER -- requirements
Module: bnn_run_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SRAM word width.
REQ-003 SHALL have parameter CYC_WIDTH, default 32, compute-cycle counter width.
REQ-004 SHALL have parameter TIMEOUT, default 4096, max cycles waiting on any dut_busy edge.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port: start  input  1  one-cycle pulse; begins a round.
REQ-009 SHALL have port: num_results  input  ADDR_WIDTH+1  words to compare, 0..4096, sampled on accepted start.
REQ-010 SHALL have port: dut_run  output  1  run request to accelerator.
REQ-011 SHALL have port: dut_busy  input  1  accelerator busy.
REQ-012 SHALL have port: res_read_address  output  ADDR_WIDTH  result SRAM read address.
REQ-013 SHALL have port: res_read_data  input  DATA_WIDTH  result SRAM data, 1-cycle latency.
REQ-014 SHALL have port: gold_read_address  output  ADDR_WIDTH  golden SRAM read address.
REQ-015 SHALL have port: gold_read_data  input  DATA_WIDTH  golden SRAM data, 1-cycle latency.
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port: done  output  1  one-cycle pulse at round end.
REQ-018 SHALL have port: timeout_err  output  1  sticky until next accepted start; set on watchdog expiry.
REQ-019 SHALL have port: correct_count  output  ADDR_WIDTH+1  matching words.
REQ-020 SHALL have port: first_mismatch_addr  output  ADDR_WIDTH  lowest mismatching address; all-ones if none.
REQ-021 SHALL have port: compute_cycles  output  CYC_WIDTH  cycles from dut_run rise to dut_busy fall.

Function
REQ-022 FSM states SHALL be IDLE, WAIT_IDLE, RUN, COMPUTE, READ, DRAIN, DONE.
REQ-023 IDLE: start=1 -> WAIT_IDLE; clear counts, timeout_err, and first_mismatch_addr (to all-ones); latch num_results. start outside IDLE SHALL be ignored.
REQ-024 WAIT_IDLE: dut_busy=0 -> RUN next cycle.
REQ-025 RUN: dut_run=1; compute_cycles cleared on entry, +1 each cycle in RUN and COMPUTE; dut_busy=1 -> COMPUTE.
REQ-026 COMPUTE: dut_run=0; dut_busy=0 -> READ if latched num_results>0, else DONE; compute_cycles frozen on exit.
REQ-027 compute_cycles SHALL saturate at all-ones, never wrap.
REQ-028 Watchdog counter SHALL clear on each state entry; reaching TIMEOUT in WAIT_IDLE, RUN or COMPUTE SHALL set timeout_err, drive dut_run=0 and go to DONE.
REQ-029 READ: issue address i=0..num_results-1 on both read ports, one per cycle, identical addresses; after the last address -> DRAIN.
REQ-030 Compare SHALL occur the cycle after the address is issued (SRAM latency); equal words increment correct_count; the first mismatch latches its address.
REQ-031 DRAIN: one cycle completing the final compare -> DONE.
REQ-032 DONE: done=1 for exactly one cycle -> IDLE; result outputs hold until next accepted start.
REQ-033 Read addresses SHALL be 0 outside READ; num_results=4096 SHALL read 0..4095 without address wrap.
REQ-034 dut_busy high in IDLE SHALL have no effect.

Reset
REQ-035 On reset: state IDLE; dut_run, busy, done and timeout_err 0; counts and compute_cycles 0; first_mismatch_addr all-ones; addresses 0.
REQ-036 Reset mid-round SHALL abort immediately (dut_run=0 next edge) with no done pulse.

Structure
REQ-037 Package bnn_pkg SHALL hold the FSM state enum and ADDR_WIDTH/DATA_WIDTH/CYC_WIDTH defaults.
REQ-038 Compare pipeline (valid, address delay, equality, counters) SHALL be sub-module bnn_result_compare.

Verification
REQ-039 num_results=32, golden=result, accelerator busy for 100 cycles after run -> correct_count=32, first_mismatch_addr=12'hFFF, compute_cycles=101 (+/- the fixed handshake latency).
REQ-040 num_results=64, words 5 and 40 differ -> correct_count=62, first_mismatch_addr=5, done one cycle after last compare.
REQ-041 num_results=0 -> no READ cycles, done pulse, correct_count=0.
REQ-042 dut_busy never rises -> after 4096 RUN cycles timeout_err=1, dut_run=0, done pulse.
REQ-043 Reset asserted during COMPUTE -> next cycle IDLE, busy=0, dut_run=0, no done.
REQ-044 start pulsed during READ -> ignored; two back-to-back rounds (32 then 64 results) give independent correct results.

Source files
------------

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared FSM state type and default widths for the BNN run controller
package bnn_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CYC_WIDTH_DEF  = 32;
  localparam int TIMEOUT_DEF    = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_RUN,
    ST_COMPUTE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bnn_result_compare.sv
// rtl/bnn_result_compare.sv - one-cycle-delayed compare of result vs golden SRAM words
module bnn_result_compare
  import bnn_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic [DATA_WIDTH-1:0] gold_data,
  output logic [ADDR_WIDTH:0]   correct_count,
  output logic [ADDR_WIDTH-1:0] first_mismatch_addr
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  found_q, found_d;
  logic [ADDR_WIDTH-1:0] fma_q, fma_d;

  // SRAM data arrives one cycle after the address, so valid/address are delayed to line up.
  always_comb begin
    valid_d = issue_valid;
    addr_d  = issue_addr;
    count_d = count_q;
    found_d = found_q;
    fma_d   = fma_q;
    if (clear) begin
      count_d = '0;
      found_d = 1'b0;
      fma_d   = '1;
    end else if (valid_q) begin
      if (res_data == gold_data) begin
        count_d = count_q + (ADDR_WIDTH + 1)'(1);
      end else if (!found_q) begin
        found_d = 1'b1;
        fma_d   = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      fma_q   <= '1;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      found_q <= found_d;
      fma_q   <= fma_d;
    end
  end

  assign correct_count       = count_q;
  assign first_mismatch_addr = fma_q;

endmodule

// File: rtl/bnn_run_controller.sv
// rtl/bnn_run_controller.sv - runs the BNN accelerator, times it, and checks results against golden SRAM
module bnn_run_controller
  import bnn_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CYC_WIDTH  = CYC_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_results,
  output logic                  dut_run,
  input  logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] res_read_address,
  input  logic [DATA_WIDTH-1:0] res_read_data,
  output logic [ADDR_WIDTH-1:0] gold_read_address,
  input  logic [DATA_WIDTH-1:0] gold_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH:0]   correct_count,
  output logic [ADDR_WIDTH-1:0] first_mismatch_addr,
  output logic [CYC_WIDTH-1:0]  compute_cycles
);

  localparam int WD_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CYC_WIDTH-1:0]  cyc_q, cyc_d, cyc_sat;
  logic [WD_WIDTH-1:0]   wd_q, wd_d;
  logic                  tout_q, tout_d;
  logic                  dut_run_q, dut_run_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept, wd_expired, last_addr, watched;

  assign accept     = (state_q == ST_IDLE) && start;
  assign wd_expired = (wd_q == WD_LAST);
  assign last_addr  = ({1'b0, addr_q} == num_q - (ADDR_WIDTH + 1)'(1));
  assign cyc_sat    = (&cyc_q) ? cyc_q : cyc_q + CYC_WIDTH'(1);
  assign watched    = (state_q == ST_WAIT_IDLE) || (state_q == ST_RUN) || (state_q == ST_COMPUTE);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    addr_d  = '0;
    cyc_d   = cyc_q;
    tout_d  = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_IDLE;
          num_d   = num_results;
          cyc_d   = '0;
          tout_d  = 1'b0;
        end
      end
      ST_WAIT_IDLE: begin
        if (!dut_busy) begin
          state_d = ST_RUN;
          cyc_d   = '0;
        end else if (wd_expired) begin
          state_d = ST_DONE;
          tout_d  = 1'b1;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_sat;
        if (dut_busy) begin
          state_d = ST_COMPUTE;
        end else if (wd_expired) begin
          state_d = ST_DONE;
          tout_d  = 1'b1;
        end
      end
      ST_COMPUTE: begin
        cyc_d = cyc_sat;
        if (!dut_busy) begin
          state_d = (num_q != '0) ? ST_READ : ST_DONE;
        end else if (wd_expired) begin
          state_d = ST_DONE;
          tout_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (last_addr) state_d = ST_DRAIN;
        else           addr_d  = addr_q + ADDR_WIDTH'(1);
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Watchdog restarts on every state change and only runs while waiting on the accelerator.
    wd_d      = (watched && (state_d == state_q)) ? wd_q + WD_WIDTH'(1) : '0;
    dut_run_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      addr_q    <= '0;
      cyc_q     <= '0;
      wd_q      <= '0;
      tout_q    <= 1'b0;
      dut_run_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      addr_q    <= addr_d;
      cyc_q     <= cyc_d;
      wd_q      <= wd_d;
      tout_q    <= tout_d;
      dut_run_q <= dut_run_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  bnn_result_compare #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compare (
    .clk                 (clk),
    .reset               (reset),
    .clear               (accept),
    .issue_valid         (state_q == ST_READ),
    .issue_addr          (addr_q),
    .res_data            (res_read_data),
    .gold_data           (gold_read_data),
    .correct_count       (correct_count),
    .first_mismatch_addr (first_mismatch_addr)
  );

  assign dut_run           = dut_run_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout_err       = tout_q;
  assign compute_cycles    = cyc_q;
  assign res_read_address  = addr_q;
  assign gold_read_address = addr_q;

endmodule
